dm_port_arbiter: RTL and testbench

Two-requester arbiter for the single-port 32-word data memory (dm_4k). It shares the port between the pipeline MEM stage (cpu side) and an external loader/debug master (ext side). The cpu side has priority, and the ext side has a bounded-wait starvation guard. When the ext side wins the port while the MEM stage has an access pending, the block stalls the pipeline for one cycle.

---
 rtl/dm_port_arbiter.sv | 126 ++++++++++++
 tb/tb_dm_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single dm_4k port between the pipeline MEM
// stage (cpu side, priority) and an external loader/debug master (ext side).
// A waiting ext request is forced through after MAX_WAIT conflicting cycles;
// the ext access then takes the port for one cycle and stalls the pipeline
// if the MEM stage had an access pending, which the pipeline replays.
`timescale 1ns/1ps

module dm_port_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic          Clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic [DW-1:0] ext_rdata,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    output logic          dm_DMWr,
    output logic          dm_DMemR,
    input  logic [DW-1:0] dm_dout,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arbStateT;

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    arbStateT   state;
    arbStateT   nextState;
    logic [3:0] waitCnt;
    logic [3:0] nextWaitCnt;
    logic       cpuAccess;
    logic       extOwns;
    logic       dmWrRaw;

    assign cpuAccess = cpu_we | cpu_re;
    assign extOwns   = (state == GRANT);

    // State register, wait counter, captured ext read data and stall statistics.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            waitCnt   <= '0;
            ext_rdata <= '0;
            stall_cnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
            if (extOwns && !ext_we) begin
                ext_rdata <= dm_dout;
            end
            if (cpu_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // Next-state logic: cpu keeps the port until ext has waited MaxWait conflicting cycles.
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        case (state)
            IDLE: begin
                if (ext_req) begin
                    if (!cpuAccess || (waitCnt >= MaxWait)) begin
                        nextState = GRANT;
                    end else begin
                        nextWaitCnt = waitCnt + 4'd1;
                    end
                end else begin
                    nextWaitCnt = '0;
                end
            end
            GRANT: begin
                nextState   = ACK;
                nextWaitCnt = '0;
            end
            ACK: begin
                nextState = IDLE;
            end
            default: begin
                nextState   = IDLE;
                nextWaitCnt = '0;
            end
        endcase
    end

    // Port muxing: ext drives dm only in GRANT; a cpu write never reaches dm then.
    always_comb begin
        dm_addr   = cpu_addr;
        dm_din    = cpu_wdata;
        dmWrRaw   = cpu_we;
        dm_DMemR  = cpu_re;
        cpu_rdata = dm_dout;
        cpu_stall = 1'b0;
        if (extOwns) begin
            dm_addr   = ext_addr;
            dm_din    = ext_wdata;
            dmWrRaw   = ext_we;
            dm_DMemR  = !ext_we;
            cpu_rdata = '0;
            cpu_stall = cpuAccess;
        end
    end

    // Writes are blocked outright while reset is asserted, independent of state.
    assign dm_DMWr = dmWrRaw & rst;
    assign ext_ack = (state == ACK);

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: behavioural dm_4k model, ext read data
// scoreboard checked on every ext_ack, and directed cycle-level checks.
`timescale 1ns/1ps

module tb_dm_port_arbiter;

    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 16;

    logic             Clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    cpu_addr;
    logic [DW-1:0]    cpu_wdata;
    logic             cpu_we;
    logic             cpu_re;
    logic [DW-1:0]    cpu_rdata;
    logic             cpu_stall;
    logic             ext_req;
    logic             ext_we;
    logic [AW-1:0]    ext_addr;
    logic [DW-1:0]    ext_wdata;
    logic             ext_ack;
    logic [DW-1:0]    ext_rdata;
    logic [AW-1:0]    dm_addr;
    logic [DW-1:0]    dm_din;
    logic             dm_DMWr;
    logic             dm_DMemR;
    logic [DW-1:0]    dm_dout;
    logic [CNT_W-1:0] stall_cnt;

    logic [DW-1:0] mem [32];
    logic          preWe;
    logic [AW-1:0] preAddr;
    logic [DW-1:0] preData;

    int            nChecks = 0;
    int            nFails  = 0;
    logic [DW-1:0] sbQueue [$];

    dm_port_arbiter #(
        .DW(DW), .AW(AW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_DMWr(dm_DMWr), .dm_DMemR(dm_DMemR),
        .dm_dout(dm_dout), .stall_cnt(stall_cnt)
    );

    always #5 Clk = ~Clk;

    // dm_4k model: combinational read, write on the rising edge; preload port for setup.
    assign dm_dout = mem[dm_addr];
    always @(posedge Clk) begin
        if (preWe) mem[preAddr] <= preData;
        else if (dm_DMWr) mem[dm_addr] <= dm_din;
    end

    task automatic checkResult(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ext_ack must match the oldest expected ext_rdata.
    always @(negedge Clk) begin : sbMonitor
        logic [31:0] expV;
        if (rst === 1'b1 && ext_ack === 1'b1) begin
            if (sbQueue.size() == 0) begin
                checkResult("extAckSpurious", 32'd1, 32'd0);
            end else begin
                expV = sbQueue.pop_front();
                checkResult("extRdata", ext_rdata, expV);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic preload(input int addr, input logic [31:0] data);
        preWe   = 1'b1;
        preAddr = AW'(addr);
        preData = data;
        step();
        preWe   = 1'b0;
    endtask

    task automatic waitAck(input int maxCycles, output int lat);
        lat = 0;
        while (ext_ack !== 1'b1 && lat < maxCycles) begin
            step();
            #1;
            lat++;
        end
        if (ext_ack !== 1'b1) checkResult("ackTimeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int stallAt;
        int ackAt;
        int stallCycles;
        int acks;
        int lastAck;

        rst = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        preWe = 1'b0; preAddr = '0; preData = '0;

        for (int i = 0; i < 32; i++) preload(i, 32'h0);
        preload(3, 32'hDEADBEEF);
        preload(2, 32'h0000_5555);

        // Reset state, and write enable forced low during reset
        cpu_we = 1'b1; cpu_addr = 5'd4;
        #1;
        checkResult("rstExtAck", 32'(ext_ack), 32'd0);
        checkResult("rstExtRdata", ext_rdata, 32'd0);
        checkResult("rstStallCnt", 32'(stall_cnt), 32'd0);
        checkResult("rstDmWr", 32'(dm_DMWr), 32'd0);
        cpu_we = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Ext read with no cpu traffic
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 5'd3;
        sbQueue.push_back(32'hDEADBEEF);
        #1;
        checkResult("t1StallIdle", 32'(cpu_stall), 32'd0);
        step(); #1;
        checkResult("t1GrantAddr", 32'(dm_addr), 32'd3);
        checkResult("t1GrantRd", 32'(dm_DMemR), 32'd1);
        checkResult("t1GrantWr", 32'(dm_DMWr), 32'd0);
        checkResult("t1GrantStall", 32'(cpu_stall), 32'd0);
        waitAck(4, lat);
        checkResult("t1Lat", 32'(lat), 32'd1);
        ext_req = 1'b0;
        step(); #1;
        checkResult("t1AckDrop", 32'(ext_ack), 32'd0);
        checkResult("t1RdataHeld", ext_rdata, 32'hDEADBEEF);
        checkResult("t1StallCnt", 32'(stall_cnt), 32'd0);

        // Ext write with no cpu traffic, then cpu reads it back
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 5'd7; ext_wdata = 32'h12345678;
        sbQueue.push_back(32'hDEADBEEF);
        waitAck(4, lat);
        checkResult("t2Lat", 32'(lat), 32'd2);
        ext_req = 1'b0; ext_we = 1'b0;
        step();
        cpu_re = 1'b1; cpu_addr = 5'd7;
        #1;
        checkResult("t2CpuRead", cpu_rdata, 32'h12345678);
        checkResult("t2CpuRdEn", 32'(dm_DMemR), 32'd1);
        cpu_re = 1'b0;
        step();

        // Starvation guard with a continuous cpu load
        cpu_re = 1'b1; cpu_addr = 5'd0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 5'd3;
        sbQueue.push_back(32'hDEADBEEF);
        stallAt = -1; ackAt = -1; stallCycles = 0;
        for (int k = 1; k <= 12; k++) begin
            step(); #1;
            if (cpu_stall === 1'b1) begin
                stallCycles++;
                if (stallAt < 0) begin
                    stallAt = k;
                    checkResult("t3GrantCpuRdata", cpu_rdata, 32'd0);
                end
            end
            if (ext_ack === 1'b1) begin
                ackAt = k;
                ext_req = 1'b0;
                checkResult("t3StallCnt", 32'(stall_cnt), 32'd1);
                break;
            end
        end
        checkResult("t3GrantCycle", 32'(stallAt), 32'(MAX_WAIT + 1));
        checkResult("t3AckCycle", 32'(ackAt), 32'(MAX_WAIT + 2));
        checkResult("t3StallCycles", 32'(stallCycles), 32'd1);
        cpu_re = 1'b0;
        step();

        // Write collision in the GRANT cycle, cpu replays in ACK
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 5'd2;
        sbQueue.push_back(32'h0000_5555);
        step();
        cpu_we = 1'b1; cpu_addr = 5'd2; cpu_wdata = 32'h0000_AAAA;
        #1;
        checkResult("t4GrantWr", 32'(dm_DMWr), 32'd0);
        checkResult("t4GrantStall", 32'(cpu_stall), 32'd1);
        checkResult("t4GrantAddr", 32'(dm_addr), 32'd2);
        step(); #1;
        checkResult("t4Ack", 32'(ext_ack), 32'd1);
        ext_req = 1'b0;
        checkResult("t4ReplayWr", 32'(dm_DMWr), 32'd1);
        step();
        cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 5'd2;
        #1;
        checkResult("t4ReplayData", cpu_rdata, 32'h0000_AAAA);
        checkResult("t4StallCnt", 32'(stall_cnt), 32'd2);
        cpu_re = 1'b0;
        step();

        // Back-to-back ext requests under continuous cpu load
        cpu_re = 1'b1; cpu_addr = 5'd3;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 5'd7;
        for (int i = 0; i < 3; i++) sbQueue.push_back(32'h12345678);
        acks = 0; lastAck = -100;
        for (int k = 1; k <= 40; k++) begin
            step(); #1;
            if (ext_ack === 1'b1) begin
                if (acks > 0) checkResult("t5AckGap", 32'((k - lastAck) >= 2), 32'd1);
                checkResult("t5AckOwner", 32'(dm_addr), 32'd3);
                checkResult("t5AckCpuRdata", cpu_rdata, 32'hDEADBEEF);
                checkResult("t5AckNoStall", 32'(cpu_stall), 32'd0);
                lastAck = k;
                acks++;
                if (acks == 3) begin
                    ext_req = 1'b0;
                    break;
                end
            end
        end
        checkResult("t5AckCount", 32'(acks), 32'd3);
        cpu_re = 1'b0;
        step(); #1;
        checkResult("t5StallCnt", 32'(stall_cnt), 32'd5);

        // Reset asserted in the middle of a GRANT cycle
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 5'd9; ext_wdata = 32'hCAFEF00D;
        step(); #1;
        checkResult("t6GrantWr", 32'(dm_DMWr), 32'd1);
        rst = 1'b0;
        #1;
        checkResult("t6RstDmWr", 32'(dm_DMWr), 32'd0);
        checkResult("t6RstAck", 32'(ext_ack), 32'd0);
        checkResult("t6RstRdata", ext_rdata, 32'd0);
        checkResult("t6RstStallCnt", 32'(stall_cnt), 32'd0);
        ext_req = 1'b0; ext_we = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        cpu_re = 1'b1; cpu_addr = 5'd9;
        #1;
        checkResult("t6NoWrite", cpu_rdata, 32'd0);
        checkResult("t6NoAck", 32'(ext_ack), 32'd0);
        cpu_re = 1'b0;
        step();
        step();

        checkResult("sbEmpty", 32'(sbQueue.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
